i2c_ram_arbiter: RTL and testbench
==================================

// Module: i2c_ram_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between two requesters: the I2C subordinate's RAM
//  state machine and a local host port. Only one access reaches the RAM at a time; read data
//  returns to the requester that issued the read.
//  Sits between the I2C subordinate core, the host logic and the RAM macro.
// PARAMETERS
//  ADDR_W         8  RAM address width
//  DATA_W         8  RAM data width
//  HOST_WAIT_MAX  4  host arbitration losses before host is forced to win (>=1)
// PORTS
//  clk          in   1       system clock, all logic rising-edge
//  reset_n      in   1       synchronous active-low reset
//  i2c_req      in   1       I2C access request; held with fields stable until i2c_gnt
//  i2c_we       in   1       1=write, 0=read
//  i2c_addr     in   ADDR_W  I2C access address
//  i2c_wdata    in   DATA_W  I2C write data
//  i2c_gnt      out  1       1-cycle pulse: I2C access issued to RAM this cycle
//  i2c_rvalid   out  1       1-cycle pulse: i2c_rdata valid
//  i2c_rdata    out  DATA_W  read data to I2C side
//  host_req/host_we/host_addr/host_wdata  in  1/1/ADDR_W/DATA_W  host request (same rules as i2c_*)
//  host_gnt/host_rvalid/host_rdata        out 1/1/DATA_W          host grant and read return
//  ram_en       out  1       RAM access enable
//  ram_we       out  1       RAM write enable
//  ram_addr     out  ADDR_W  RAM address
//  ram_wdata    out  DATA_W  RAM write data
//  ram_rdata    in   DATA_W  RAM read data, valid 1 cycle after ram_en&&!ram_we
//  arb_state    out  5       current one-hot state (debug)
// BEHAVIOUR
//  One clock, synchronous active-low reset. Reset: state=ARB_IDLE and every output 0.
//  The wait counter is also cleared.
//  One-hot FSM: ARB_IDLE, ARB_I2C_ACCESS, ARB_HOST_ACCESS, ARB_I2C_RDATA, ARB_HOST_RDATA.
//  IDLE: neither req -> stay. Only one req -> that requester's ACCESS state.
//   Both req -> I2C wins unless wait_cnt==HOST_WAIT_MAX, in which case host wins.
//  ACCESS (1 cycle): ram_en=1; ram_we/addr/wdata are taken combinationally from the owner.
//   The owner's gnt=1. Write -> IDLE. Read -> matching RDATA state.
//  RDATA (1 cycle): owner's rvalid=1 and rdata=ram_rdata; non-owner rdata holds 0.
//   Next state is IDLE.
//  Latency from req high in IDLE: gnt at +1 cycle, rvalid at +2 cycles.
//   Throughput is one write per 2 cycles or one read per 3 cycles.
//  wait_cnt: increments in IDLE when both req are high and I2C wins; saturates at HOST_WAIT_MAX.
//   Clears on entry to ARB_HOST_ACCESS. Width is $clog2(HOST_WAIT_MAX+1).
//  ram_en/ram_we/gnt are 0 in every state except ACCESS. rvalid is 0 except in RDATA.
//  A req dropped before gnt is a protocol violation; behaviour is undefined and there is no assertion.
//  A req still high after gnt is a new transaction, arbitrated in the next IDLE.
//  reset_n low mid-operation: the next edge forces IDLE and clears all outputs.
//   An in-flight read is discarded, and no rvalid is issued after reset releases.
//  A non-one-hot state (illegal) returns to IDLE on the next edge.
// CONFIGURATION
//  I2C_RAM_ARB_RR_EN defined: round-robin arbitration.
//   On a tie, the requester not granted last wins; last-grant starts as host after reset, so I2C wins first.
//   wait_cnt and HOST_WAIT_MAX are unused.
//  I2C_RAM_ARB_RR_EN undefined: fixed I2C priority with host anti-starvation as above.
// STRUCTURE
//  arb_state_bit and arb_state_t (5-bit, 1<<bit encoding) are added to i2c_state_pkg.
//   They follow the same pattern as the existing sub_state_t and ram_state_t.
//  No sub-module; the grant-pick logic and wait counter stay inline.
// TESTING
//  Reset: hold reset_n=0 for 2 cycles with both reqs high -> all outputs 0, arb_state=5'b00001.
//  I2C write 0x05<=0xA5, then read 0x05 -> gnt at +1 with ram_we=1, ram_addr=0x05.
//   The read returns i2c_rvalid at +2 with i2c_rdata=0xA5.
//  Both req together, I2C writes 0x10<=0x11, host writes 0x20<=0x22 -> I2C granted first, host next.
//   Host reads of 0x10/0x20 then return 0x11/0x22.
//  Starvation, HOST_WAIT_MAX=3, both reqs held continuously -> three I2C grants, then a host grant.
//   wait_cnt returns to 0.
//  Reset pulse in ARB_I2C_RDATA -> i2c_rvalid=0 on the next edge.
//   No rvalid appears after release until a new request is made.
//  RR_EN build, both reqs held -> grants strictly alternate I2C, host, I2C, host, ...

Source files
------------

// File: rtl/i2c_state_pkg.sv
// i2c_state_pkg: shared state encodings for the I2C subordinate blocks.
// Arbiter states are one-hot: each arb_state_t value is 1 << its arb_state_bit.
package i2c_state_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE_B        = 3'd0,
        ARB_I2C_ACCESS_B  = 3'd1,
        ARB_HOST_ACCESS_B = 3'd2,
        ARB_I2C_RDATA_B   = 3'd3,
        ARB_HOST_RDATA_B  = 3'd4
    } arb_state_bit;

    typedef enum logic [4:0] {
        ARB_IDLE        = 5'd1 << ARB_IDLE_B,
        ARB_I2C_ACCESS  = 5'd1 << ARB_I2C_ACCESS_B,
        ARB_HOST_ACCESS = 5'd1 << ARB_HOST_ACCESS_B,
        ARB_I2C_RDATA   = 5'd1 << ARB_I2C_RDATA_B,
        ARB_HOST_RDATA  = 5'd1 << ARB_HOST_RDATA_B
    } arb_state_t;

endpackage

// File: rtl/i2c_ram_arbiter.sv
// i2c_ram_arbiter: shares one single-port RAM between the I2C RAM FSM and the host port.
// Define I2C_RAM_ARB_RR_EN for round-robin ties instead of I2C priority with host anti-starvation.
module i2c_ram_arbiter
    import i2c_state_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int HOST_WAIT_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i2c_req,
    input  logic              i2c_we,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    output logic              i2c_gnt,
    output logic              i2c_rvalid,
    output logic [DATA_W-1:0] i2c_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [4:0]        arb_state
);

    arb_state_t state, state_nxt;
    logic       host_pick;

`ifdef I2C_RAM_ARB_RR_EN
    logic last_host;

    assign host_pick = host_req && (!i2c_req || !last_host);

    always_ff @(posedge clk)
        if (!reset_n)                  last_host <= 1'b1;
        else if (state == ARB_I2C_ACCESS)  last_host <= 1'b0;
        else if (state == ARB_HOST_ACCESS) last_host <= 1'b1;
`else
    localparam int               CNT_W   = $clog2(HOST_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOST_WAIT_MAX);
    logic [CNT_W-1:0] wait_cnt;

    assign host_pick = host_req && (!i2c_req || wait_cnt == CNT_MAX);

    // counts host losses on ties; cleared whenever the host is granted
    always_ff @(posedge clk)
        if (!reset_n)
            wait_cnt <= '0;
        else if (state == ARB_IDLE && host_pick)
            wait_cnt <= '0;
        else if (state == ARB_IDLE && i2c_req && host_req && wait_cnt != CNT_MAX)
            wait_cnt <= wait_cnt + 1'b1;
`endif

    always_ff @(posedge clk)
        state <= !reset_n ? ARB_IDLE : state_nxt;

    assign arb_state = state;

    always_comb begin
        state_nxt   = ARB_IDLE;
        i2c_gnt     = 1'b0;
        i2c_rvalid  = 1'b0;
        i2c_rdata   = '0;
        host_gnt    = 1'b0;
        host_rvalid = 1'b0;
        host_rdata  = '0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        case (state)
            ARB_IDLE:
                if (i2c_req || host_req)
                    state_nxt = host_pick ? ARB_HOST_ACCESS : ARB_I2C_ACCESS;
            ARB_I2C_ACCESS: begin
                ram_en    = 1'b1;
                ram_we    = i2c_we;
                ram_addr  = i2c_addr;
                ram_wdata = i2c_wdata;
                i2c_gnt   = 1'b1;
                state_nxt = i2c_we ? ARB_IDLE : ARB_I2C_RDATA;
            end
            ARB_HOST_ACCESS: begin
                ram_en    = 1'b1;
                ram_we    = host_we;
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
                host_gnt  = 1'b1;
                state_nxt = host_we ? ARB_IDLE : ARB_HOST_RDATA;
            end
            ARB_I2C_RDATA: begin
                i2c_rvalid = 1'b1;
                i2c_rdata  = ram_rdata;
            end
            ARB_HOST_RDATA: begin
                host_rvalid = 1'b1;
                host_rdata  = ram_rdata;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_ram_arbiter.sv
// tb_i2c_ram_arbiter: directed scenarios plus randomized traffic against a spec-level
// arbitration and memory model; a behavioural RAM macro sits behind the DUT.
module tb_i2c_ram_arbiter;

    localparam int MAXW = 3;
`ifdef I2C_RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i2c_req = 1'b0, i2c_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
    logic [7:0] i2c_addr = '0, i2c_wdata = '0, host_addr = '0, host_wdata = '0;
    logic       i2c_gnt, i2c_rvalid, host_gnt, host_rvalid, ram_en, ram_we;
    logic [7:0] i2c_rdata, host_rdata, ram_addr, ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic [4:0] arb_state;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    i2c_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .HOST_WAIT_MAX(MAXW)) dut (
        .clk(clk), .reset_n(reset_n),
        .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_gnt(i2c_gnt), .i2c_rvalid(i2c_rvalid), .i2c_rdata(i2c_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        i2c_req = 1'b0;
        host_req = 1'b0;
        step;
        step;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        i2c_req = 1'b1;
        host_req = 1'b1;
        i2c_we = 1'($urandom);
        host_we = 1'($urandom);
        i2c_addr = 8'($urandom);
        host_wdata = 8'($urandom);
        step;
        step;
        @(negedge clk);
        checks++;
        if ({i2c_gnt, i2c_rvalid, host_gnt, host_rvalid, ram_en, ram_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {i2c_gnt, i2c_rvalid, host_gnt, host_rvalid, ram_en, ram_we});
        end
        checks++;
        if ({ram_addr, ram_wdata} !== 16'h0) begin
            errors++;
            $display("FAIL reset_ram got %h exp 0000", {ram_addr, ram_wdata});
        end
        checks++;
        if ({i2c_rdata, host_rdata} !== 16'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h exp 0000", {i2c_rdata, host_rdata});
        end
        checks++;
        if (arb_state !== 5'b00001) begin
            errors++;
            $display("FAIL reset_state got %b exp 00001", arb_state);
        end
        step;
        i2c_req = 1'b0;
        host_req = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_i2c_write_read;
        i2c_req = 1'b1;
        i2c_we = 1'b1;
        i2c_addr = 8'h05;
        i2c_wdata = 8'hA5;
        @(negedge clk);
        checks++;
        if (i2c_gnt !== 1'b0) begin
            errors++;
            $display("FAIL wr_gnt_early got %b exp 0", i2c_gnt);
        end
        step;
        @(negedge clk);
        checks++;
        if ({i2c_gnt, host_gnt, ram_en, ram_we, ram_addr, ram_wdata} !== {4'b1011, 8'h05, 8'hA5}) begin
            errors++;
            $display("FAIL wr_access got %h exp %h", {i2c_gnt, host_gnt, ram_en, ram_we, ram_addr, ram_wdata}, {4'b1011, 8'h05, 8'hA5});
        end
        step;
        i2c_we = 1'b0;
        @(negedge clk);
        checks++;
        if (i2c_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rd_gnt_early got %b exp 0", i2c_gnt);
        end
        step;
        @(negedge clk);
        checks++;
        if ({i2c_gnt, ram_en, ram_we, ram_addr} !== {3'b110, 8'h05}) begin
            errors++;
            $display("FAIL rd_access got %h exp %h", {i2c_gnt, ram_en, ram_we, ram_addr}, {3'b110, 8'h05});
        end
        step;
        i2c_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({i2c_rvalid, i2c_rdata, host_rvalid, host_rdata} !== {1'b1, 8'hA5, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rd_data got %h exp %h", {i2c_rvalid, i2c_rdata, host_rvalid, host_rdata}, {1'b1, 8'hA5, 1'b0, 8'h00});
        end
        step;
        @(negedge clk);
        checks++;
        if ({i2c_rvalid, arb_state} !== 6'b000001) begin
            errors++;
            $display("FAIL rd_done got %b exp 000001", {i2c_rvalid, arb_state});
        end
        step;
    endtask

    task automatic test_both_write;
        i2c_req = 1'b1;
        i2c_we = 1'b1;
        i2c_addr = 8'h10;
        i2c_wdata = 8'h11;
        host_req = 1'b1;
        host_we = 1'b1;
        host_addr = 8'h20;
        host_wdata = 8'h22;
        step;
        @(negedge clk);
        checks++;
        if ({i2c_gnt, host_gnt, ram_addr, ram_wdata} !== {2'b10, 8'h10, 8'h11}) begin
            errors++;
            $display("FAIL both_first got %h exp %h", {i2c_gnt, host_gnt, ram_addr, ram_wdata}, {2'b10, 8'h10, 8'h11});
        end
        step;
        i2c_req = 1'b0;
        step;
        @(negedge clk);
        checks++;
        if ({i2c_gnt, host_gnt, ram_addr, ram_wdata} !== {2'b01, 8'h20, 8'h22}) begin
            errors++;
            $display("FAIL both_second got %h exp %h", {i2c_gnt, host_gnt, ram_addr, ram_wdata}, {2'b01, 8'h20, 8'h22});
        end
        step;
        for (int k = 0; k < 2; k++) begin
            host_req = 1'b1;
            host_we = 1'b0;
            host_addr = (k == 0) ? 8'h10 : 8'h20;
            step;
            @(negedge clk);
            checks++;
            if ({host_gnt, ram_we, ram_addr} !== {2'b10, host_addr}) begin
                errors++;
                $display("FAIL host_rd_gnt%0d got %h exp %h", k, {host_gnt, ram_we, ram_addr}, {2'b10, host_addr});
            end
            step;
            host_req = 1'b0;
            @(negedge clk);
            checks++;
            if ({host_rvalid, host_rdata, i2c_rvalid} !== {1'b1, (k == 0) ? 8'h11 : 8'h22, 1'b0}) begin
                errors++;
                $display("FAIL host_rd_data%0d got %h exp %h", k, {host_rvalid, host_rdata, i2c_rvalid}, {1'b1, (k == 0) ? 8'h11 : 8'h22, 1'b0});
            end
            step;
        end
    endtask

    task automatic test_starvation;
        int  n;
        bit  gi, gh, exp_host;
        n = 0;
        i2c_req = 1'b1;
        host_req = 1'b1;
        i2c_we = 1'b1;
        host_we = 1'b1;
        i2c_addr = 8'h30 | 8'($urandom_range(0, 15));
        host_addr = 8'h30 | 8'($urandom_range(0, 15));
        i2c_wdata = 8'($urandom);
        host_wdata = 8'($urandom);
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge clk);
            gi = i2c_gnt;
            gh = host_gnt;
            if (gi || gh) begin
                exp_host = RR ? (n % 2 == 1) : (n % (MAXW + 1) == MAXW);
                checks++;
                if ({gi, gh} !== {!exp_host, exp_host}) begin
                    errors++;
                    $display("FAIL starve_grant%0d got %b exp %b", n, {gi, gh}, {!exp_host, exp_host});
                end
                n++;
            end
            step;
            if (gi) begin
                i2c_addr = 8'h30 | 8'($urandom_range(0, 15));
                i2c_wdata = 8'($urandom);
            end
            if (gh) begin
                host_addr = 8'h30 | 8'($urandom_range(0, 15));
                host_wdata = 8'($urandom);
            end
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL starve_count got %0d exp 8", n);
        end
        i2c_req = 1'b0;
        host_req = 1'b0;
        step;
    endtask

    task automatic test_reset_rdata;
        for (int p = 1; p <= 2; p++) begin
            i2c_req = 1'b1;
            i2c_we = 1'b0;
            i2c_addr = 8'h05;
            step;
            i2c_req = 1'b0;
            if (p == 2) step;
            reset_n = 1'b0;
            step;
            @(negedge clk);
            checks++;
            if ({i2c_rvalid, i2c_rdata, i2c_gnt, ram_en, arb_state} !== {12'h000, 5'b00001}) begin
                errors++;
                $display("FAIL rst_inflight%0d got %h exp %h", p, {i2c_rvalid, i2c_rdata, i2c_gnt, ram_en, arb_state}, {12'h000, 5'b00001});
            end
            step;
            reset_n = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                checks++;
                if ({i2c_rvalid, host_rvalid, i2c_gnt, host_gnt} !== 4'b0) begin
                    errors++;
                    $display("FAIL rst_quiet%0d_%0d got %b exp 0000", p, c, {i2c_rvalid, host_rvalid, i2c_gnt, host_gnt});
                end
                step;
            end
        end
    endtask

    task automatic test_random;
        bit         prev_idle, pi, ph, rd_pend, rd_host, last_host, exp_gnt, hw, exp_rv, gi, gh;
        int         losses;
        logic       w_we;
        logic [7:0] w_addr, w_wdata, rd_data;
        do_reset;
        prev_idle = 1'b1;
        pi = 1'b0;
        ph = 1'b0;
        rd_pend = 1'b0;
        rd_host = 1'b0;
        last_host = 1'b1;
        losses = 0;
        rd_data = '0;
        w_we = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            exp_gnt = prev_idle && (pi || ph);
            hw = ph && (!pi || (RR ? !last_host : losses == MAXW));
            gi = exp_gnt && !hw;
            gh = exp_gnt && hw;
            exp_rv = rd_pend;
            checks++;
            if ({i2c_gnt, host_gnt, ram_en} !== {gi, gh, exp_gnt}) begin
                errors++;
                $display("FAIL rnd_gnt c=%0d got %b exp %b", c, {i2c_gnt, host_gnt, ram_en}, {gi, gh, exp_gnt});
            end
            if (exp_gnt) begin
                w_we = hw ? host_we : i2c_we;
                w_addr = hw ? host_addr : i2c_addr;
                w_wdata = hw ? host_wdata : i2c_wdata;
                checks++;
                if ({ram_we, ram_addr, ram_wdata} !== {w_we, w_addr, w_wdata}) begin
                    errors++;
                    $display("FAIL rnd_ram c=%0d got %h exp %h", c, {ram_we, ram_addr, ram_wdata}, {w_we, w_addr, w_wdata});
                end
            end
            checks++;
            if ({i2c_rvalid, i2c_rdata, host_rvalid, host_rdata} !==
                {exp_rv && !rd_host, (exp_rv && !rd_host) ? rd_data : 8'h00,
                 exp_rv && rd_host, (exp_rv && rd_host) ? rd_data : 8'h00}) begin
                errors++;
                $display("FAIL rnd_rdata c=%0d got %h exp rvalid_i=%b rvalid_h=%b data=%h", c,
                         {i2c_rvalid, i2c_rdata, host_rvalid, host_rdata}, exp_rv && !rd_host, exp_rv && rd_host, rd_data);
            end
            if (exp_gnt) begin
                if (w_we) ref_mem[w_addr] = w_wdata;
                else rd_data = ref_mem[w_addr];
                if (hw) losses = 0;
                else if (pi && ph && losses < MAXW) losses++;
                last_host = hw;
            end
            rd_pend = exp_gnt && !w_we;
            rd_host = hw;
            prev_idle = !exp_gnt && !exp_rv;
            pi = i2c_req;
            ph = host_req;
            step;
            if (!i2c_req || gi) begin
                i2c_req = ($urandom_range(0, 99) < 60);
                i2c_we = 1'($urandom);
                i2c_addr = 8'hC0 | 8'($urandom_range(0, 7));
                i2c_wdata = 8'($urandom);
            end
            if (!host_req || gh) begin
                host_req = ($urandom_range(0, 99) < 60);
                host_we = 1'($urandom);
                host_addr = 8'hC0 | 8'($urandom_range(0, 7));
                host_wdata = 8'($urandom);
            end
        end
        i2c_req = 1'b0;
        host_req = 1'b0;
    endtask

    initial begin
        test_reset;
        test_i2c_write_read;
        test_both_write;
        test_starvation;
        test_reset_rdata;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
